// File: rtl/uart_rx_if.sv
// Serial RX pin plus received-byte/status outputs of uart_rx.
// slave: the receiver; master: the pin driver and byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport slave  (input rx,  output data, output valid, output frame_err, output parity_err, output busy);
  modport master (output rx, input data,  input valid,  input frame_err,  input parity_err,  input busy);
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with mid-bit sampling, stop-bit check and one-cycle strobes.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err strobe.
module uart_rx #(
  parameter int unsigned freq = 12000000,
  parameter int unsigned baud = 9600,
  parameter int unsigned lim  = freq / baud
) (
  input  logic      clk,
  input  logic      nrst,
  uart_rx_if.slave  bus
);

  localparam int unsigned   CW      = $clog2(lim);
  localparam logic [CW-1:0] HALF_M1 = CW'(lim / 2 - 1);
  localparam logic [CW-1:0] LIM_M1  = CW'(lim - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    RECOVER
  } state_e;

  logic          rx_meta_q;
  logic          rx_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LIM_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LIM_M1) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LIM_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) perr_d = 1'b1;
            else
`endif
            begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            // A bad stop bit wins over a parity mismatch; only frame_err fires.
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the 8N1 link driven by the team's UART transmitter. It oversamples the incoming line with the system clock, validates the start bit at mid-bit, and shifts in 8 data bits LSB first. It checks the stop bit and presents each good byte with a one-cycle valid strobe. It sits at the board RX pin, ahead of any byte consumer logic.

## Interface
- `freq`, 12000000, system clock frequency in Hz
- `baud`, 9600, line bit rate
- `lim`, freq/baud (1250), clock cycles per bit; must be ≥ 8; counter width `$clog2(lim)`
- `clk`  input  1  system clock, rising edge
- `nrst`  input  1  asynchronous, active-low reset
- `rx`  input  1  serial line, idle high, asynchronous to `clk`
- `data`  output  8  last good received byte
- `valid`  output  1  one-cycle pulse when `data` is updated
- `frame_err`  output  1  one-cycle pulse on a bad stop bit
- `parity_err`  output  1  one-cycle pulse on a parity mismatch; constant 0 without the parity macro
- `busy`  output  1  high whenever the state is not IDLE

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized `rx_s`.
- States:
  - **IDLE**: on `rx_s`==0, go to START and clear `cnt`.
  - **START**: when `cnt`==lim/2−1, sample `rx_s`.
    - If 0, go to DATA with `cnt`=0 and `bit_idx`=0.
    - If 1, treat it as a glitch and return to IDLE with no output.
  - **DATA**: when `cnt`==lim−1, sample `rx_s` into `shift[bit_idx]` and clear `cnt`.
    - After `bit_idx`==7, go to STOP, or to PARITY when the macro is defined.
  - **PARITY** (macro only): when `cnt`==lim−1, sample `rx_s` and store mismatch = `rx_s` ≠ ^`shift`. Parity is even. Then go to STOP.
  - **STOP**: when `cnt`==lim−1, sample `rx_s`.
    - If 1 and there is no parity mismatch: load `data` from `shift`, pulse `valid`, go to IDLE.
    - If 1 with a parity mismatch: pulse `parity_err`, leave `data` unchanged, go to IDLE.
    - If 0: pulse `frame_err` (`parity_err` is not also pulsed), leave `data` unchanged, go to RECOVER.
  - **RECOVER**: wait for `rx_s`==1, then go to IDLE. A held-low break never produces repeated errors.
- `valid`, `frame_err` and `parity_err` are mutually exclusive. Each is high for exactly one `clk` cycle.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state=IDLE, `cnt`=0, `bit_idx`=0, `shift`=0x00.
- Asserting `nrst` mid-frame aborts the frame immediately. No strobe is generated for the partial frame. After release, the receiver waits in IDLE for the next falling edge.

## Timing
- Synchronizer latency is 2 cycles from the `rx` transition to `rx_s`.
- Sampling points relative to the start edge seen on `rx_s`: mid-start at lim/2 cycles, then one point every lim cycles.
- Strobe rises in the cycle after the stop-bit sample.
  - 8N1: about 2 + lim/2 + 9·lim + 1 cycles after the `rx` falling edge. Bench tolerance is ±2 cycles.
  - With parity: add lim.
- The receiver returns to IDLE half a bit before the end of the stop bit. A start bit that immediately follows a stop bit (zero idle gap) is caught.
- `busy` rises 1 cycle after `rx_s` falls in IDLE. It falls in the same cycle the strobe rises.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the frame is 8E1, the PARITY state exists, and `parity_err` is live.
  - Undefined: the frame is 8N1, the PARITY state is not built, and `parity_err` is tied to 0.

## Test plan
- **Good byte:** send 0x54 8N1 at lim=1250 → single `valid` pulse, `data`=0x54, `frame_err`=0, `busy` low after the pulse.
- **Start glitch:** drive `rx` low for 300 cycles, then high → no strobe, `busy` returns to 0 about 625 cycles after the edge, `data` unchanged.
- **Framing error:** send 0x54, then 0xA5 with stop bit=0 held low for 5000 cycles → one `frame_err` pulse, `data` stays 0x54. After the line returns high, 0x0F is received with `valid` and `data`=0x0F.
- **Reset mid-frame:** pulse `nrst` low after 4 data bits of 0x3C → all outputs at reset values, no strobe; the next full frame 0x3C gives `data`=0x3C.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `valid` pulses about 10·lim apart, `data`=0x00 then 0xFF.
- **Parity (`UART_RX_PARITY_EN` defined):**
  - 0x54 with parity bit 1 → `valid`, `data`=0x54.
  - 0x54 with parity bit 0 → `parity_err` pulse, no `valid`, `data` unchanged.
